// File: rtl/pico_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pico_ctrl_pkg
//  Description : Shared types and constants for the picoMIPS control path:
//                opcode encoding and the sequencer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package pico_ctrl_pkg;

    // Opcode field width of an instruction word.
    localparam int OPW = 4;

    // Opcode encoding. Codes not listed here execute as NOP.
    typedef enum logic [OPW-1:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_ADDI = 4'd2,
        OP_MUL  = 4'd3,
        OP_BEQ  = 4'd4,
        OP_BNE  = 4'd5,
        OP_JMP  = 4'd6,
        OP_WAIT = 4'd7,
        OP_HALT = 4'd15
    } opcode_t;

    // Sequencer states.
    typedef enum logic [2:0] {
        S_RUN        = 3'd0,
        S_MUL_WAIT   = 3'd1,
        S_IO_PRESS   = 3'd2,
        S_IO_RELEASE = 3'd3,
        S_HALT       = 3'd4
    } seq_state_t;

endpackage : pico_ctrl_pkg
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Two-flop synchroniser for a single asynchronous level.
//  Ports       : clk    - destination clock
//                reset  - asynchronous active-low reset (flops clear to 0)
//                d_i    - asynchronous input level
//                q_o    - synchronised level, two clk edges behind d_i
//  Revision    : 1.0  initial release
// ============================================================================
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync2
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : picoMIPS control FSM. Decodes the opcode at the current PC
//                and drives the PC increment / absolute-branch controls and
//                the register-file write path. Holds the PC during multi-cycle
//                multiply and the switch-input handshake; stops on HALT.
//  Ports       : clk          - system clock
//                reset        - asynchronous active-low reset
//                opcode       - opcode of the instruction at the current PC
//                imm_target   - branch / jump target field
//                alu_zero     - ALU zero flag for the current instruction
//                sw_ready     - asynchronous "input valid" button
//                pc_incr      - PC increment
//                pc_absbranch - PC load of branch_addr
//                branch_addr  - absolute branch target
//                rf_we        - register-file write enable
//                in_sel       - write data comes from the switch input
//                mul_start    - one-cycle multiplier start pulse
//                halted       - sequencer has executed HALT
//  Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer
    import pico_ctrl_pkg::*;
#(
    parameter int Psize      = 6,
    parameter int OPW        = pico_ctrl_pkg::OPW,
    parameter int MUL_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPW-1:0]   opcode,
    input  logic [Psize-1:0] imm_target,
    input  logic             alu_zero,
    input  logic             sw_ready,
    output logic             pc_incr,
    output logic             pc_absbranch,
    output logic [Psize-1:0] branch_addr,
    output logic             rf_we,
    output logic             in_sel,
    output logic             mul_start,
    output logic             halted
);

    localparam int CNTW = $clog2(MUL_CYCLES + 1);

    seq_state_t      state_q, state_d;
    logic [CNTW-1:0] cnt_q,   cnt_d;
    logic            sw_s;
    opcode_t         op_w;

    logic incr_w, abs_w, we_w, insel_w, mstart_w, halt_w;

    // The button is asynchronous; only its synchronised copy reaches the FSM.
    sync2 u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (sw_ready),
        .q_o   (sw_s)
    );

    assign op_w = opcode_t'(opcode);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        incr_w   = 1'b0;
        abs_w    = 1'b0;
        we_w     = 1'b0;
        insel_w  = 1'b0;
        mstart_w = 1'b0;
        halt_w   = 1'b0;

        case (state_q)
            S_RUN: begin
                case (op_w)
                    OP_ADD, OP_ADDI: begin
                        we_w   = 1'b1;
                        incr_w = 1'b1;
                    end
                    OP_BEQ: begin
                        abs_w  = alu_zero;
                        incr_w = !alu_zero;
                    end
                    OP_BNE: begin
                        abs_w  = !alu_zero;
                        incr_w = alu_zero;
                    end
                    OP_JMP: begin
                        abs_w = 1'b1;
                    end
                    OP_MUL: begin
                        // Issue cycle counts as the first of the hold cycles,
                        // so the down-counter starts one short.
                        mstart_w = 1'b1;
                        cnt_d    = CNTW'(MUL_CYCLES - 1);
                        state_d  = S_MUL_WAIT;
                    end
                    OP_WAIT: begin
                        state_d = S_IO_PRESS;
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                    end
                    default: begin
                        // NOP and all unassigned codes just advance.
                        incr_w = 1'b1;
                    end
                endcase
            end

            S_MUL_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNTW'(1);
                end else begin
                    we_w    = 1'b1;
                    incr_w  = 1'b1;
                    state_d = S_RUN;
                end
            end

            S_IO_PRESS: begin
                if (sw_s) begin
                    state_d = S_IO_RELEASE;
                end
            end

            S_IO_RELEASE: begin
                // Retire on release so one press completes exactly one WAIT.
                if (!sw_s) begin
                    we_w    = 1'b1;
                    insel_w = 1'b1;
                    incr_w  = 1'b1;
                    state_d = S_RUN;
                end
            end

            S_HALT: begin
                halt_w = 1'b1;
            end

            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Outputs are forced low while reset is held so an aborted MUL or WAIT
    // can never leak a write or a PC change.
    assign pc_incr      = reset & incr_w;
    assign pc_absbranch = reset & abs_w;
    assign rf_we        = reset & we_w;
    assign in_sel       = reset & insel_w;
    assign mul_start    = reset & mstart_w;
    assign halted       = reset & halt_w;
    assign branch_addr  = reset ? imm_target : '0;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer. Directed scenarios plus
//                a randomized run compared against a behavioural model that
//                tracks pending multiply age, I/O handshake progress and halt.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int PSIZE = 6;
    localparam int OPW   = 4;
    localparam int MULC  = 3;

    localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, ADDI = 4'd2, MUL = 4'd3,
                           BEQ = 4'd4, BNE = 4'd5, JMP = 4'd6, WAITO = 4'd7,
                           HALTO = 4'd15;

    // Observed output vector: {pc_incr, pc_absbranch, rf_we, in_sel, mul_start, halted}
    localparam logic [5:0] O_NONE = 6'b000000, O_INC = 6'b100000,
                           O_ABS  = 6'b010000, O_WE  = 6'b001000,
                           O_IN   = 6'b000100, O_MS  = 6'b000010,
                           O_HLT  = 6'b000001;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [OPW-1:0]   opcode = '0;
    logic [PSIZE-1:0] imm_target = '0;
    logic             alu_zero = 1'b0;
    logic             sw_ready = 1'b0;
    logic             pc_incr, pc_absbranch, rf_we, in_sel, mul_start, halted;
    logic [PSIZE-1:0] branch_addr;
    logic [5:0]       obs;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit m_halted, m_mul, m_io, m_pressed, m_sw1, m_sws;
    int m_age;

    pc_sequencer #(.Psize(PSIZE), .OPW(OPW), .MUL_CYCLES(MULC)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .imm_target   (imm_target),
        .alu_zero     (alu_zero),
        .sw_ready     (sw_ready),
        .pc_incr      (pc_incr),
        .pc_absbranch (pc_absbranch),
        .branch_addr  (branch_addr),
        .rf_we        (rf_we),
        .in_sel       (in_sel),
        .mul_start    (mul_start),
        .halted       (halted)
    );

    assign obs = {pc_incr, pc_absbranch, rf_we, in_sel, mul_start, halted};

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    // Expected outputs for the current cycle from the model and live inputs.
    function automatic logic [5:0] exp_out();
        if (!reset)   return O_NONE;
        if (m_halted) return O_HLT;
        if (m_mul)    return (m_age == MULC) ? (O_INC | O_WE) : O_NONE;
        if (m_io)     return (m_pressed && !m_sws) ? (O_INC | O_WE | O_IN) : O_NONE;
        case (opcode)
            ADD, ADDI:    return O_INC | O_WE;
            BEQ:          return alu_zero ? O_ABS : O_INC;
            BNE:          return alu_zero ? O_INC : O_ABS;
            JMP:          return O_ABS;
            MUL:          return O_MS;
            WAITO, HALTO: return O_NONE;
            default:      return O_INC;
        endcase
    endfunction

    function automatic logic [PSIZE-1:0] exp_ba();
        return reset ? imm_target : '0;
    endfunction

    // Advance the model across one rising edge.
    function automatic void model_step();
        bit sws_old;
        sws_old = m_sws;
        if (!reset) begin
            m_halted = 0; m_mul = 0; m_io = 0; m_pressed = 0;
            m_sw1 = 0; m_sws = 0; m_age = 0;
            return;
        end
        m_sws = m_sw1;
        m_sw1 = sw_ready;
        if (m_halted) begin
        end else if (m_mul) begin
            if (m_age == MULC) m_mul = 0;
            else               m_age++;
        end else if (m_io) begin
            if (!m_pressed) begin
                if (sws_old) m_pressed = 1;
            end else if (!sws_old) begin
                m_io = 0;
            end
        end else begin
            case (opcode)
                MUL:     begin m_mul = 1; m_age = 1; end
                WAITO:   begin m_io = 1; m_pressed = 0; end
                HALTO:   m_halted = 1;
                default: ;
            endcase
        end
    endfunction

    task automatic drive(input logic rst, input logic [3:0] op,
                         input logic [PSIZE-1:0] tgt, input logic z, input logic sw);
        @(negedge clk);
        reset = rst; opcode = op; imm_target = tgt; alu_zero = z; sw_ready = sw;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, ADD, 6'd5, 1'b0, 1'b0);
            n_vec++;
            if (obs !== O_NONE || branch_addr !== 6'd0) begin
                n_err++;
                $display("FAIL reset_outputs cyc%0d: got %b/%0d want %b/0", i, obs, branch_addr, O_NONE);
            end
            tick();
        end
        drive(1'b1, ADD, 6'd5, 1'b0, 1'b0);
        n_vec++;
        if (obs !== (O_INC | O_WE)) begin
            n_err++;
            $display("FAIL reset_release_add: got %b want %b", obs, O_INC | O_WE);
        end
        tick();
    endtask

    task automatic test_branch();
        logic [3:0] ops [2];
        logic [5:0] want;
        ops[0] = BEQ; ops[1] = BNE;
        for (int o = 0; o < 2; o++) begin
            for (int z = 0; z < 2; z++) begin
                drive(1'b1, ops[o], 6'd12, z[0], 1'b0);
                want = ((o == 0) == (z == 1)) ? O_ABS : O_INC;
                n_vec++;
                if (obs !== want || branch_addr !== 6'd12) begin
                    n_err++;
                    $display("FAIL branch op%0d z%0d: got %b/%0d want %b/12", ops[o], z, obs, branch_addr, want);
                end
                tick();
            end
        end
        drive(1'b1, JMP, 6'd33, 1'b0, 1'b0);
        n_vec++;
        if (obs !== O_ABS || branch_addr !== 6'd33) begin
            n_err++;
            $display("FAIL jmp: got %b/%0d want %b/33", obs, branch_addr, O_ABS);
        end
        tick();
    endtask

    task automatic test_mul();
        drive(1'b1, MUL, 6'd0, 1'b0, 1'b0);
        n_vec++;
        if (obs !== O_MS) begin
            n_err++;
            $display("FAIL mul_issue: got %b want %b", obs, O_MS);
        end
        tick();
        // Opcode ADD during the wait would advance the PC if it were decoded.
        for (int k = 1; k <= MULC; k++) begin
            drive(1'b1, ADD, 6'd0, 1'b0, 1'b0);
            n_vec++;
            if (obs !== ((k == MULC) ? (O_INC | O_WE) : O_NONE)) begin
                n_err++;
                $display("FAIL mul_wait k%0d: got %b want %b", k, obs,
                         (k == MULC) ? (O_INC | O_WE) : O_NONE);
            end
            tick();
        end
        drive(1'b1, NOP, 6'd0, 1'b0, 1'b0);
        n_vec++;
        if (obs !== O_INC) begin
            n_err++;
            $display("FAIL mul_back_to_run: got %b want %b", obs, O_INC);
        end
        tick();
    endtask

    task automatic test_wait();
        int hits = 0;
        int hit_k = -1;
        drive(1'b1, WAITO, 6'd0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, ADD, 6'd0, 1'b0, (i >= 10));
            n_vec++;
            if (obs !== O_NONE) begin
                n_err++;
                $display("FAIL wait_hold cyc%0d: got %b want %b", i, obs, O_NONE);
            end
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, NOP, 6'd0, 1'b0, 1'b0);
            n_vec++;
            if (obs !== exp_out()) begin
                n_err++;
                $display("FAIL wait_release k%0d: got %b want %b", k, obs, exp_out());
            end
            if (obs === (O_INC | O_WE | O_IN)) begin
                hits++;
                hit_k = k;
            end
            tick();
        end
        n_vec++;
        if (hits != 1 || hit_k < 2 || hit_k > 3) begin
            n_err++;
            $display("FAIL wait_retire_count: got %0d retires at k=%0d want 1 at k=2..3", hits, hit_k);
        end
    endtask

    task automatic test_reset_abort();
        drive(1'b1, MUL, 6'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, ADD, 6'd0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, NOP, 6'd0, 1'b0, 1'b0);
            n_vec++;
            if (obs !== O_NONE) begin
                n_err++;
                $display("FAIL abort_during_reset cyc%0d: got %b want %b", i, obs, O_NONE);
            end
            tick();
        end
        drive(1'b1, NOP, 6'd0, 1'b0, 1'b0);
        n_vec++;
        if (obs !== O_INC) begin
            n_err++;
            $display("FAIL abort_back_to_run: got %b want %b", obs, O_INC);
        end
        tick();
    endtask

    task automatic test_halt();
        drive(1'b1, HALTO, 6'd0, 1'b0, 1'b0);
        n_vec++;
        if (obs !== O_NONE) begin
            n_err++;
            $display("FAIL halt_issue: got %b want %b", obs, O_NONE);
        end
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 4'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));
            n_vec++;
            if (obs !== O_HLT) begin
                n_err++;
                $display("FAIL halt_hold cyc%0d: got %b want %b", i, obs, O_HLT);
            end
            tick();
        end
        drive(1'b0, NOP, 6'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, NOP, 6'd0, 1'b0, 1'b0);
        n_vec++;
        if (obs !== O_INC) begin
            n_err++;
            $display("FAIL halt_cleared_by_reset: got %b want %b", obs, O_INC);
        end
        tick();
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic       sw = 1'b0;
        logic       rst;
        for (int i = 0; i < 600; i++) begin
            op = 4'($urandom_range(0, 14));
            if ($urandom_range(0, 3) == 0) sw = ~sw;
            rst = ($urandom_range(0, 99) != 0);
            drive(rst, op, 6'($urandom), 1'($urandom), sw);
            n_vec++;
            if (obs !== exp_out() || branch_addr !== exp_ba()) begin
                n_err++;
                $display("FAIL random cyc%0d op%0d: got %b/%0d want %b/%0d",
                         i, op, obs, branch_addr, exp_out(), exp_ba());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_mul();
        test_wait();
        test_reset_abort();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire
